// File: rtl/fpmul_issue_pkg.sv
// Shared definitions for the FP multiplier issue sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fpmul_issue_pkg;

  // Exception flag vector layout, MSB first: {OF, UF, NanF, InfF, DNF, ZF}
  localparam int FLAGS_W   = 6;
  localparam int FLAG_OF   = 5;
  localparam int FLAG_UF   = 4;
  localparam int FLAG_NANF = 3;
  localparam int FLAG_INFF = 2;
  localparam int FLAG_DNF  = 1;
  localparam int FLAG_ZF   = 0;

  // IEEE-754 single operand width
  localparam int OPND_W = 32;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/fpmul_issue_fifo.sv
// Operand FIFO: DEPTH x W synchronous queue with an explicit occupancy count.
// Latency: a write is visible at the head on the following cycle; head read is combinational.
// Backpressure: writes while full and reads while empty are dropped; callers gate on full/empty.
module fpmul_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 68
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr_ok;
  logic          rd_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful behind the count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fpmul_issue.sv
// Operand-side sequencer for the FP multiplier: queues tagged pairs, runs one Start/Done job at a time.
// Latency: issue one cycle after the pair reaches the FIFO head; out_valid one cycle after mul_done.
// Backpressure: in_ready drops only when the FIFO is full; a held result blocks the next issue.
module fpmul_issue
  import fpmul_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPND_W-1:0]  in_a,
  input  logic [OPND_W-1:0]  in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               mul_start,
  output logic [OPND_W-1:0]  mul_a,
  output logic [OPND_W-1:0]  mul_b,
  input  logic               mul_done,
  input  logic [OPND_W-1:0]  mul_p,
  input  logic [FLAGS_W-1:0] mul_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPND_W-1:0]  out_p,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy,
  output logic [CNT_W-1:0]   job_count
);

  localparam int ENT_W = 2 * OPND_W + TAG_W;

  state_t             state;
  state_t             state_nxt;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENT_W-1:0]   fifo_wr_ent;
  logic [ENT_W-1:0]   fifo_head;
  logic               push;
  logic               issue;
  logic               capture;
  logic [TAG_W-1:0]   tag_q;

  // Ready is forced low while reset is held so nothing is accepted during reset.
  assign in_ready    = rst && !fifo_full;
  assign push        = in_valid && in_ready;
  assign fifo_wr_ent = {in_tag, in_a, in_b};
  assign busy        = (state == ST_BUSY);

  fpmul_issue_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (fifo_wr_ent),
    .rd_en   (issue),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state and control: Start is held through BUSY and dropped combinationally on Done.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    mul_start = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty && !out_valid) begin
          issue     = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        mul_start = !mul_done;
        if (mul_done) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand holding registers: loaded on pop and kept stable while the multiply runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a <= '0;
      mul_b <= '0;
      tag_q <= '0;
    end else if (issue) begin
      tag_q <= fifo_head[ENT_W-1 -: TAG_W];
      mul_a <= fifo_head[2*OPND_W-1 -: OPND_W];
      mul_b <= fifo_head[OPND_W-1:0];
    end
  end

  // Result slot and completion counter; product and flags are only valid in the Done cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_flags <= '0;
      out_tag   <= '0;
      job_count <= '0;
    end else begin
      if (capture) begin
        out_valid <= 1'b1;
        out_p     <= mul_p;
        out_flags <= mul_flags;
        out_tag   <= tag_q;
        job_count <= job_count + CNT_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fpmul_issue.md
Name: fpmul_issue

Overview:
Operand-side sequencer that sits directly in front of the FP multiplier. It accepts tagged operand pairs on a valid/ready stream and buffers them in a small FIFO. It launches one multiply at a time using the multiplier's Start/Done protocol, captures the product and the six exception flags on the Done cycle, and presents them on a valid/ready result stream. It lets upstream producers and downstream consumers stall freely without knowing the multiplier's multi-cycle timing.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, 2..16.
- TAG_W, 4, width of the opaque tag carried from operand to result.
- CNT_W, 16, width of the completed-job counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept (not full).
- in_a  in  32  IEEE-754 single operand A.
- in_b  in  32  IEEE-754 single operand B.
- in_tag  in  TAG_W  job tag.
- mul_start  out  1  Start to multiplier.
- mul_a  out  32  operand A to multiplier.
- mul_b  out  32  operand B to multiplier.
- mul_done  in  1  Done from multiplier (one-cycle pulse).
- mul_p  in  32  product; valid only in the mul_done cycle.
- mul_flags  in  6  {OF,UF,NanF,InfF,DNF,ZF}; valid only in the mul_done cycle.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_p  out  32  captured product.
- out_flags  out  6  captured flags, same order as mul_flags.
- out_tag  out  TAG_W  tag of the job.
- busy  out  1  multiply in flight.
- job_count  out  CNT_W  completed jobs, wraps modulo 2^CNT_W.

Behaviour:
Reset:
- All outputs are 0 during and after reset: in_ready=0 while rst=0 and 1 on the first cycle after release.
- FIFO empty, FSM in IDLE, job_count=0.
- Reset mid-job abandons the job and the in-flight tag. The multiplier shares the same reset source (inverted at top level to match its polarity).

FIFO:
- Write when in_valid && in_ready; read when the FSM issues.
- Simultaneous read and write while full is not allowed: in_ready depends only on the full state, no same-cycle bypass.
- Pointers are DEPTH-wrapping, with an explicit count register (log2(DEPTH)+1 bits).

FSM states: IDLE, BUSY, HOLD.
- IDLE: if FIFO non-empty and out_valid=0, pop the head into the mul_a/mul_b/tag holding registers, set mul_start=1, and go to BUSY. Otherwise stay.
- BUSY:
  - mul_start stays 1 and mul_a/mul_b stay stable until mul_done, because the multiplier samples Start only in its wait state.
  - On mul_done: mul_start=0 the same cycle (combinational deassert). Capture mul_p, mul_flags and the tag into the out registers, set out_valid=1, increment job_count, go to HOLD.
  - busy=1 throughout BUSY.
- HOLD: stay while out_valid && !out_ready. On handshake, clear out_valid and go to IDLE. The next issue may happen in the following cycle.

Other rules:
- Issue is gated on an empty result slot, so a Done can never be lost. mul_p/mul_flags are cleared by the multiplier the cycle after Done and must never be read later.
- mul_done seen outside BUSY is ignored, and no counter changes.
- Latency: issue-to-out_valid = multiplier latency + 1 (8 cycles from its load cycle for normal operands, 5 for NaN/Inf/zero operands).
- Operand-to-result order is strict FIFO.
- out_* stable while out_valid && !out_ready.

Decomposition:
- Shared package: flag bit indices (FLAG_OF=5 … FLAG_ZF=0), FLAGS_W=6, FSM state encoding.
- One natural sub-module: fpmul_issue_fifo (DEPTH×(64+TAG_W) sync FIFO with full/empty/count).

Test Plan:
- Single job: A=0x40000000 (2.0), B=0x40400000 (3.0), tag 3, out_ready=1 → one out_valid pulse with out_p=0x40C00000, flags=0, tag=3, job_count=1. mul_start is high from issue until the Done cycle.
- Special operand: A=0x7FC00000, B=0x3F800000 → out_p=0x7FFFFFFF, NanF=1 only. Result arrives 3 cycles sooner than the normal job.
- Back-pressure: queue 4 jobs with out_ready=0 → first result held stable, no second mul_start, in_ready=0 after the 4th accept plus one issued entry refills the FIFO. Releasing out_ready drains the results in order with tags 0..3.
- FIFO boundary: push DEPTH+1 jobs back-to-back → in_ready drops at full. Wrap-around after draining 6 more jobs shows no tag or operand corruption.
- Reset mid-job: assert rst=0 during BUSY → all outputs 0. After release, a new job 0x3F800000×0x3F800000 returns 0x3F800000, job_count=1.
- Overflow flag: A=B=0x7F000000 → OF=1, result forwarded unchanged from the multiplier, job_count increments.
